// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits in either order,
// optional odd/even parity and 1 or 2 stop bits, paced by an external baud strobe.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_pulse,
    input  logic                 req,
    input  logic [DATA_BITS-1:0] byte_in,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_BITS);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stop_q, stop_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    function automatic logic next_bit(input logic [DATA_BITS-1:0] d);
        return (LSB_FIRST != 0) ? d[0] : d[DATA_BITS-1];
    endfunction

    function automatic logic [DATA_BITS-1:0] shifted(input logic [DATA_BITS-1:0] d);
        return (LSB_FIRST != 0) ? {1'b0, d[DATA_BITS-1:1]} : {d[DATA_BITS-2:0], 1'b0};
    endfunction

    // Every transition and every tx change is gated by the baud strobe.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        stop_d   = stop_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (baud_pulse) begin
            case (state_q)
                S_IDLE: begin
                    if (req && !busy_q) begin
                        shreg_d  = byte_in;
                        parity_d = parity_of(byte_in);
                        busy_d   = 1'b1;
                        tx_d     = 1'b0;
                        cnt_d    = '0;
                        state_d  = S_START;
                    end
                end
                S_START: begin
                    tx_d    = next_bit(shreg_q);
                    shreg_d = shifted(shreg_q);
                    cnt_d   = CNT_W'(1);
                    state_d = S_DATA;
                end
                S_DATA: begin
                    // cnt_q counts bits already driven; at LAST_CNT the final bit has had its period.
                    if (cnt_q == LAST_CNT) begin
                        if (PARITY != 0) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d    = next_bit(shreg_q);
                        shreg_d = shifted(shreg_q);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (stop_q == LAST_STOP) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    // Asynchronous reset aborts a frame at once: line idles high, busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            stop_q   <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            stop_q   <= stop_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameter variants driven one at a time, checked against
// literal frame vectors and a string-building frame model.
module tb_uart_tx_frame;

    localparam int NCFG = 5;
    localparam int DB  [NCFG] = '{8, 8, 8, 8, 7};
    localparam int PAR [NCFG] = '{0, 2, 1, 0, 0};
    localparam int STP [NCFG] = '{1, 1, 1, 1, 2};
    localparam int LSB [NCFG] = '{1, 1, 1, 0, 1};

    logic            clk;
    logic            rst_n;
    logic            baud_pulse;
    logic [NCFG-1:0] req_v;
    logic [8:0]      din;
    logic [NCFG-1:0] tx_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;
    int baud_cnt = 0;
    int baud_div = 2;
    int acc_bc = 0;
    int done_bc = 0;

    uart_tx_frame #(.DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(STP[0]), .LSB_FIRST(LSB[0])) u0 (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .req(req_v[0]), .byte_in(din[7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));
    uart_tx_frame #(.DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(STP[1]), .LSB_FIRST(LSB[1])) u1 (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .req(req_v[1]), .byte_in(din[7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));
    uart_tx_frame #(.DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(STP[2]), .LSB_FIRST(LSB[2])) u2 (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .req(req_v[2]), .byte_in(din[7:0]),
        .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));
    uart_tx_frame #(.DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(STP[3]), .LSB_FIRST(LSB[3])) u3 (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .req(req_v[3]), .byte_in(din[7:0]),
        .busy(busy_v[3]), .done(done_v[3]), .tx(tx_v[3]));
    uart_tx_frame #(.DATA_BITS(DB[4]), .PARITY(PAR[4]), .STOP_BITS(STP[4]), .LSB_FIRST(LSB[4])) u4 (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .req(req_v[4]), .byte_in(din[6:0]),
        .busy(busy_v[4]), .done(done_v[4]), .tx(tx_v[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud strobe: one high cycle every baud_div clocks (baud_div=1 holds it high).
    initial begin
        int div_cnt;
        div_cnt = 0;
        baud_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div_cnt = (div_cnt + 1 >= baud_div) ? 0 : div_cnt + 1;
            baud_pulse = (div_cnt == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (baud_pulse) baud_cnt++;
        end
    end

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    function automatic string bit_ch(input logic b);
        if (b === 1'b1) return "1";
        if (b === 1'b0) return "0";
        return "x";
    endfunction

    // Reference frame: start, data in line order, optional parity, stop bits; one char per period.
    function automatic string model(input int k, input logic [8:0] d);
        string s;
        logic  p;
        int    idx;
        s = "0";
        p = 1'b0;
        for (int i = 0; i < DB[k]; i++) begin
            idx = (LSB[k] != 0) ? i : DB[k] - 1 - i;
            s = {s, bit_ch(d[idx])};
            p = p ^ d[i];
        end
        if (PAR[k] == 1) s = {s, bit_ch(~p)};
        if (PAR[k] == 2) s = {s, bit_ch(p)};
        for (int i = 0; i < STP[k]; i++) s = {s, "1"};
        return s;
    endfunction

    task automatic wait_baud(output bit timed_out);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!baud_pulse && t < 100);
        timed_out = !baud_pulse;
    endtask

    // Sends one frame on instance k and checks the line, busy and done period by period.
    task automatic frame(input int k, input logic [8:0] data, input string exp, input bit keep_req,
                         input logic [8:0] next_data, input int pulse_at, input int rst_at);
        string got;
        int    n;
        int    t;
        bit    busy_ok, done_ok, to;
        got = "";
        n = exp.len();
        busy_ok = 1'b1;
        done_ok = 1'b1;
        din = data;
        req_v[k] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!busy_v[k] && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!busy_v[k]) begin
            chk_int("accept_timeout", 0, 1);
            req_v[k] = 1'b0;
            return;
        end
        acc_bc = baud_cnt;
        if (!keep_req) req_v[k] = 1'b0;
        din = ~data;
        got = {got, bit_ch(tx_v[k])};
        if (done_v[k]) done_ok = 1'b0;
        for (int i = 1; i < n; i++) begin
            wait_baud(to);
            if (to) begin
                chk_int("baud_timeout", 0, 1);
                return;
            end
            @(negedge clk);
            if (i == pulse_at) req_v[k] = 1'b1;
            if (i == pulse_at + 1) req_v[k] = 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_int("rst_abort_tx", tx_v[k], 1);
                chk_int("rst_abort_busy", busy_v[k], 0);
                done_ok = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    if (done_v[k]) done_ok = 1'b0;
                end
                rst_n = 1'b1;
                req_v[k] = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (done_v[k] || busy_v[k]) done_ok = 1'b0;
                end
                chk_int("rst_no_done", done_ok, 1);
                return;
            end
            got = {got, bit_ch(tx_v[k])};
            if (!busy_v[k]) busy_ok = 1'b0;
            if (done_v[k]) done_ok = 1'b0;
        end
        wait_baud(to);
        @(negedge clk);
        chk_str($sformatf("frame_cfg%0d_%0h", k, data), got, exp);
        chk_int("busy_in_frame", busy_ok, 1);
        chk_int("done_not_early", done_ok, 1);
        chk_int("done_at_end", done_v[k], 1);
        chk_int("busy_low_at_end", busy_v[k], 0);
        chk_int("tx_idle_at_end", tx_v[k], 1);
        done_bc = baud_cnt;
        if (keep_req) din = next_data;
        @(negedge clk);
        chk_int("done_clears", done_v[k], 0);
    endtask

    typedef struct {
        int         cfg;
        logic [8:0] data;
        string      exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   prev_done;
        bit   to;
        bit   quiet;
        int   k;
        logic [8:0] d;

        vecs[0] = '{0, 9'h0A5, "0101001011"};
        vecs[1] = '{1, 9'h0A5, "01010010101"};
        vecs[2] = '{2, 9'h0A5, "01010010111"};
        vecs[3] = '{2, 9'h001, "01000000001"};
        vecs[4] = '{3, 9'h00F, "0000011111"};
        vecs[5] = '{4, 9'h055, "0101010111"};

        rst_n = 1'b0;
        req_v = '0;
        din = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            chk_int("reset_tx", tx_v[i], 1);
            chk_int("reset_busy", busy_v[i], 0);
            chk_int("reset_done", done_v[i], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            baud_div = (i % 3) + 1;
            frame(vecs[i].cfg, vecs[i].data, vecs[i].exp, 1'b0, 9'h000, 0, 0);
            repeat (3) @(negedge clk);
        end

        // Back-to-back with req held: next start at the first baud after done.
        baud_div = 3;
        frame(0, 9'h012, model(0, 9'h012), 1'b1, 9'h034, 0, 0);
        prev_done = done_bc;
        frame(0, 9'h034, model(0, 9'h034), 1'b0, 9'h000, 0, 0);
        chk_int("b2b_start_after_done", acc_bc - prev_done, 1);
        repeat (3) @(negedge clk);

        // A req pulse while busy must not spawn a frame.
        baud_div = 2;
        frame(0, 9'h03C, model(0, 9'h03C), 1'b0, 9'h000, 3, 0);
        quiet = 1'b1;
        repeat (4) begin
            wait_baud(to);
            @(negedge clk);
            if (busy_v[0] || !tx_v[0]) quiet = 1'b0;
        end
        chk_int("req_during_busy_ignored", quiet, 1);

        // Reset during data bit 3, then a clean frame.
        frame(0, 9'h0A5, vecs[0].exp, 1'b0, 9'h000, 0, 4);
        frame(0, 9'h0A5, vecs[0].exp, 1'b0, 9'h000, 0, 0);

        for (int r = 0; r < 30; r++) begin
            k = $urandom_range(0, NCFG - 1);
            d = 9'($urandom);
            baud_div = $urandom_range(1, 4);
            frame(k, d, model(k, d), 1'b0, 9'h000, 0, 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
